soml_metric_min: RTL
====================

# soml_metric_min

Per-frame minimum-metric selector for the SOML decoder, directly downstream of the read-address generator. For each of NCAND candidate symbols it accumulates BEATS partial error-energy terms, produced by the metric datapath in the address generator's column/row order, into one candidate metric. It tracks the running minimum and reports the winning candidate index and its metric once per frame. A frame starts on the same `start` pulse that restarts the address generator.

## Interface
- NCAND, default 16: candidates per frame. Power of two, at least 2.
- BEATS, default 8: partial terms per candidate. Power of two, at least 2.
- ERR_W, default 16: width of one unsigned partial term.
- ACC_W, derived localparam ERR_W+$clog2(BEATS): accumulator and metric width. Cannot overflow.
- IDX_W, derived localparam $clog2(NCAND).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; clears and arms a new frame.
- in_valid  in  1  in_err carries a valid partial term this cycle.
- in_err  in  ERR_W  unsigned partial error energy.
- busy  out  1  frame armed and not yet complete.
- out_valid  out  1  one-cycle pulse; result fields valid.
- best_idx  out  IDX_W  index of the minimum-metric candidate.
- best_metric  out  ACC_W  metric of that candidate.

## Operation
- States: IDLE, ACCUM.
- IDLE:
  - busy=0; in_valid is ignored.
  - start → ACCUM, with beat_cnt=0, cand_cnt=0, acc=0, min_metric=all-ones, min_idx=0.
- ACCUM, each cycle with in_valid=1:
  - sum = acc + in_err, computed at ACC_W width.
  - beat_cnt < BEATS-1: acc ← sum, beat_cnt++.
  - beat_cnt == BEATS-1 (candidate end):
    - Compare sum against min_metric. Strictly less → min_metric ← sum, min_idx ← cand_cnt. Ties keep the earlier, lower index.
    - acc ← 0, beat_cnt ← 0, cand_cnt++.
  - Candidate end with cand_cnt == NCAND-1 (frame end): result is committed using the updated minimum, including candidate NCAND-1. Next cycle: out_valid=1, best_idx/best_metric loaded, state → IDLE.
- in_valid=0 in ACCUM: hold all state. Gaps between beats are legal.
- start during ACCUM aborts the current frame, re-initialises as from IDLE, and produces no out_valid for the aborted frame.
- start and in_valid in the same cycle: start wins and that beat is discarded.
- start in the same cycle as the frame-end beat: the frame-end beat is discarded, no out_valid is produced, and a new frame is armed.
- best_idx/best_metric hold their value after out_valid until the next frame result.

## Timing
- Reset values: busy=0, out_valid=0, best_idx=0, best_metric=0. Internal state: IDLE, counters 0, min_metric all-ones.
- rst has priority over start, including mid-frame.
- busy rises the cycle after start. It falls in the same cycle out_valid rises.
- Latency: out_valid is asserted exactly 1 cycle after the final beat (cand NCAND-1, beat BEATS-1) is accepted.
- Minimum frame length: NCAND×BEATS accepted beats (128 at defaults). Back-to-back frames: start may be asserted in the cycle out_valid is high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package soml_pkg holds:
  - SOML_NCAND=16, SOML_BEATS=8, SOML_ERR_W=16.
  - State enum type soml_min_state_t.
- The address generator uses the same NCAND/BEATS constants, so candidate/beat order stays consistent.
- One sub-module: soml_min_tracker, containing the compare-and-update register pair (min_metric, min_idx) with a clear input and the strict-less rule.
- Counters, accumulator and FSM live in the top module. Target 150–250 RTL lines.

## Test plan
- Defaults. start, then 128 consecutive beats with in_err=100, except candidate 5 uses in_err=10 on all beats → one out_valid, 1 cycle after beat 128; best_idx=5, best_metric=80.
- Tie: candidates 3 and 9 both sum to 40, all others sum to 800 → best_idx=3, best_metric=40.
- Overflow corner: all in_err=16'hFFFF, with 17 random idle cycles inserted → best_idx=0, best_metric=19'h7FFF8, out_valid exactly once; busy stays 1 through the gaps.
- Abort: start, 50 beats, start again, then 128 beats with minimum at candidate 15 (sum 7) → single out_valid; best_idx=15, best_metric=7.
- Reset mid-frame: rst after 70 beats, followed by 128 beats without start → no out_valid, busy=0 throughout, outputs remain 0.
- Back-to-back: start asserted in the out_valid cycle, then a second frame with minimum at candidate 0 → two out_valid pulses 129 cycles apart; second result best_idx=0.

Source files
------------

// File: rtl/soml_pkg.sv
// soml_pkg: constants and types shared by the SOML decoder blocks.
// The address generator and the minimum-metric selector both use
// SOML_NCAND/SOML_BEATS, so their candidate/beat ordering stays consistent.
package soml_pkg;

  localparam int SOML_NCAND = 16;  // candidates per frame
  localparam int SOML_BEATS = 8;   // partial terms per candidate
  localparam int SOML_ERR_W = 16;  // width of one partial error term

  typedef enum logic [0:0] {
    SOML_MIN_IDLE  = 1'b0,
    SOML_MIN_ACCUM = 1'b1
  } soml_min_state_t;

endpackage : soml_pkg

// File: rtl/soml_metric_min_if.sv
// soml_metric_min_if: frame-control, beat-input and result bundle of the
// minimum-metric selector.
//
// Handshake: start is a one-cycle pulse that (re)arms a frame. in_valid
// qualifies in_err for exactly the cycle it is high; there is no ready,
// every valid beat seen while a frame is armed is accepted. out_valid is a
// one-cycle pulse and best_idx/best_metric hold until the next result.
// state is a debug view of the selector FSM.
//
// Modports:
//   master - drives start/in_valid/in_err, observes the results.
//   slave  - the selector itself.
interface soml_metric_min_if
  import soml_pkg::*;
#(
  parameter int ERR_W = SOML_ERR_W,
  parameter int ACC_W = SOML_ERR_W + $clog2(SOML_BEATS),
  parameter int IDX_W = $clog2(SOML_NCAND)
);
  logic             start;
  logic             in_valid;
  logic [ERR_W-1:0] in_err;
  logic             busy;
  logic             out_valid;
  logic [IDX_W-1:0] best_idx;
  logic [ACC_W-1:0] best_metric;
  soml_min_state_t  state;

  modport master (
    output start, in_valid, in_err,
    input  busy, out_valid, best_idx, best_metric, state
  );

  modport slave (
    input  start, in_valid, in_err,
    output busy, out_valid, best_idx, best_metric, state
  );
endinterface : soml_metric_min_if

// File: rtl/soml_min_tracker.sv
// soml_min_tracker: running-minimum register pair (metric, index).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_clear         re-initialise for a new frame (metric all-ones, idx 0)
//   i_update        a candidate metric is complete this cycle
//   i_metric/i_idx  the completed candidate's metric and index
//   o_next_metric   minimum including the current candidate (combinational),
//   o_next_idx      so the frame-end beat can commit without an extra cycle
module soml_min_tracker #(
  parameter int ACC_W = 19,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_update,
  input  logic [ACC_W-1:0] i_metric,
  input  logic [IDX_W-1:0] i_idx,
  output logic [ACC_W-1:0] o_next_metric,
  output logic [IDX_W-1:0] o_next_idx
);

  logic [ACC_W-1:0] r_min_metric;
  logic [IDX_W-1:0] r_min_idx;
  logic             w_less;

  // Strictly less: on a tie the earlier (lower) index is kept.
  assign w_less = i_metric < r_min_metric;

  always_comb begin
    o_next_metric = r_min_metric;
    o_next_idx    = r_min_idx;
    if (i_update && w_less) begin
      o_next_metric = i_metric;
      o_next_idx    = i_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_min_metric <= '1;
      r_min_idx    <= '0;
    end else if (i_update) begin
      r_min_metric <= o_next_metric;
      r_min_idx    <= o_next_idx;
    end
  end

endmodule : soml_min_tracker

// File: rtl/soml_metric_min.sv
// soml_metric_min: per-frame minimum-metric selector of the SOML decoder.
// Accumulates BEATS partial error terms per candidate, NCAND candidates per
// frame, and reports the index and metric of the smallest candidate once
// per frame, one cycle after the last beat.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset (priority over start)
//   bus       soml_metric_min_if.slave: start, in_valid, in_err in;
//             busy, out_valid, best_idx, best_metric, state out (registered)
module soml_metric_min
  import soml_pkg::*;
#(
  parameter int NCAND = SOML_NCAND,
  parameter int BEATS = SOML_BEATS,
  parameter int ERR_W = SOML_ERR_W
) (
  input  logic clk,
  input  logic rst,
  soml_metric_min_if.slave bus
);

  localparam int ACC_W  = ERR_W + $clog2(BEATS);
  localparam int IDX_W  = $clog2(NCAND);
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(NCAND - 1);

  soml_min_state_t   r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [IDX_W-1:0]  r_cand_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_busy;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_best_idx;
  logic [ACC_W-1:0]  r_best_metric;

  logic [ACC_W-1:0]  w_sum;
  logic              w_beat_take;
  logic              w_cand_end;
  logic              w_frame_end;
  logic [ACC_W-1:0]  w_next_metric;
  logic [IDX_W-1:0]  w_next_idx;

  // ACC_W = ERR_W + log2(BEATS) holds BEATS full-scale terms, no overflow.
  assign w_sum       = r_acc + ACC_W'(bus.in_err);
  // start wins over a coincident beat, which is then dropped.
  assign w_beat_take = (r_state == SOML_MIN_ACCUM) && bus.in_valid && !bus.start;
  assign w_cand_end  = w_beat_take && (r_beat_cnt == LAST_BEAT);
  assign w_frame_end = w_cand_end && (r_cand_cnt == LAST_CAND);

  soml_min_tracker #(
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (bus.start),
    .i_update      (w_cand_end),
    .i_metric      (w_sum),
    .i_idx         (r_cand_cnt),
    .o_next_metric (w_next_metric),
    .o_next_idx    (w_next_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SOML_MIN_IDLE;
      r_beat_cnt    <= '0;
      r_cand_cnt    <= '0;
      r_acc         <= '0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_best_idx    <= '0;
      r_best_metric <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.start) begin
        // Arms from IDLE or aborts a running frame without a result.
        r_state    <= SOML_MIN_ACCUM;
        r_beat_cnt <= '0;
        r_cand_cnt <= '0;
        r_acc      <= '0;
        r_busy     <= 1'b1;
      end else if (w_beat_take) begin
        if (w_cand_end) begin
          r_acc      <= '0;
          r_beat_cnt <= '0;
          r_cand_cnt <= r_cand_cnt + IDX_W'(1);
          if (w_frame_end) begin
            // Commit uses the minimum updated with the last candidate.
            r_state       <= SOML_MIN_IDLE;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b1;
            r_best_idx    <= w_next_idx;
            r_best_metric <= w_next_metric;
          end
        end else begin
          r_acc      <= w_sum;
          r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.out_valid   = r_out_valid;
  assign bus.best_idx    = r_best_idx;
  assign bus.best_metric = r_best_metric;
  assign bus.state       = r_state;

endmodule : soml_metric_min
